// File: rtl/dcache_controller.sv
// Blocking, write-back, write-allocate, direct-mapped data cache controller.
// A miss runs through WRITEBACK (dirty victim only) and ALLOCATE, then completes as a hit.
module dcache_controller #(
  parameter  int NUM_SETS        = 8,
  parameter  int WORDS_PER_BLOCK = 4,
  localparam int INDEX_BITS      = $clog2(NUM_SETS),
  localparam int WOFF_BITS       = $clog2(WORDS_PER_BLOCK),
  localparam int OFFSET_BITS     = WOFF_BITS + 2,
  localparam int TAG_BITS        = 32 - INDEX_BITS - OFFSET_BITS,
  localparam int BLOCK_W         = 32 * WORDS_PER_BLOCK
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [31:0]             cpu_address,
  input  logic [31:0]             cpu_writedata,
  output logic [31:0]             cpu_readdata,
  output logic                    cpu_busywait,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [31-OFFSET_BITS:0] mem_address,
  output logic [BLOCK_W-1:0]      mem_writedata,
  input  logic [BLOCK_W-1:0]      mem_readdata,
  input  logic                    mem_busywait
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  state_e state_q, state_d;

  logic [BLOCK_W-1:0]  data_q  [NUM_SETS];
  logic [TAG_BITS-1:0] tag_q   [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  logic [WOFF_BITS-1:0]  word_sel;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  unused_byte_bits;

  assign word_sel         = cpu_address[OFFSET_BITS-1:2];
  assign index            = cpu_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign tag              = cpu_address[31:OFFSET_BITS+INDEX_BITS];
  assign unused_byte_bits = ^cpu_address[1:0];

  logic        req;
  logic        hit;
  logic [31:0] hit_word;
  logic        fill_en;
  logic        wr_hit_en;

  assign req      = cpu_read | cpu_write;
  assign hit      = valid_q[index] && (tag_q[index] == tag);
  assign hit_word = data_q[index][32*word_sel +: 32];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d       = state_q;
    cpu_readdata  = '0;
    cpu_busywait  = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    fill_en       = 1'b0;
    wr_hit_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cpu_busywait = req && !hit;
        if (cpu_read && hit) cpu_readdata = hit_word;
        if (cpu_write && hit) wr_hit_en = 1'b1;
        if (req && !hit) begin
          state_d = (valid_q[index] && dirty_q[index]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end

      S_WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tag_q[index], index};
        mem_writedata = data_q[index];
        cpu_busywait  = 1'b1;
        if (!mem_busywait) state_d = S_ALLOCATE;
      end

      S_ALLOCATE: begin
        mem_read     = 1'b1;
        mem_address  = {tag, index};
        cpu_busywait = 1'b1;
        if (!mem_busywait) begin
          fill_en = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (wr_hit_en) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // NOTE: data and tag storage is deliberately not reset; valid_q gates every use,
  // and reset only suppresses writes so an aborted fill leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_en) begin
        data_q[index] <= mem_readdata;
        tag_q[index]  <= tag;
      end else if (wr_hit_en) begin
        data_q[index][32*word_sel +: 32] <= cpu_writedata;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller (NUM_SETS=8, WORDS_PER_BLOCK=4).
// A small responder holds mem_busywait high for mem_wait cycles per request.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_address, cpu_writedata, cpu_readdata;
  logic         cpu_busywait;
  logic         mem_read, mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata, mem_readdata;
  logic         mem_busywait;

  int vectors = 0;
  int errors  = 0;
  int mem_wait = 0;
  int wait_cnt = 0;

  int           n_busy, n_rd, n_wr;
  logic [27:0]  rd_addr, wr_addr;
  logic [127:0] wr_data;
  logic         wb_first, done;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_address  (cpu_address),
    .cpu_writedata(cpu_writedata),
    .cpu_readdata (cpu_readdata),
    .cpu_busywait (cpu_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  assign mem_busywait = (mem_read | mem_write) && (wait_cnt < mem_wait);

  always @(posedge clk) begin
    if ((mem_read | mem_write) && mem_busywait) wait_cnt <= wait_cnt + 1;
    else                                        wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns in the cycle where cpu_busywait drops.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
    cpu_read      = rd;
    cpu_write     = wr;
    cpu_address   = addr;
    cpu_writedata = wdata;
    n_busy = 0; n_rd = 0; n_wr = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    wb_first = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (mem_read) begin
        if (n_rd == 0) rd_addr = mem_address;
        n_rd++;
      end
      if (mem_write) begin
        if (n_wr == 0) begin
          wr_addr  = mem_address;
          wr_data  = mem_writedata;
          wb_first = (n_rd == 0);
        end
        n_wr++;
      end
      if (cpu_busywait) begin
        n_busy++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    check("access_done", done, 1'b1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_writedata = '0;
    mem_readdata = '0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_mem_read",  mem_read,     1'b0);
    check("rst_mem_write", mem_write,    1'b0);
    check("rst_busywait",  cpu_busywait, 1'b0);
    check("rst_readdata",  cpu_readdata, 32'h0);

    // Clean miss on 0x40, memory busy for 3 cycles.
    next_cycle();
    mem_wait = 3;
    mem_readdata = {32'h4, 32'h3, 32'h2, 32'h1};
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("miss40_busy",     n_busy, 5);
    check("miss40_rd_cnt",   n_rd, 4);
    check("miss40_rd_addr",  rd_addr, 28'h000_0004);
    check("miss40_wr_cnt",   n_wr, 0);
    check("miss40_readdata", cpu_readdata, 32'h0000_0001);

    // Write hit, then read it back.
    next_cycle();
    access(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
    check("wr44_busy",     n_busy, 0);
    check("wr44_readdata", cpu_readdata, 32'h0);
    next_cycle();
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    check("rd44_busy",     n_busy, 0);
    check("rd44_readdata", cpu_readdata, 32'hDEAD_BEEF);

    // Conflict miss on dirty line 4: writeback, then allocate.
    next_cycle();
    mem_wait = 1;
    mem_readdata = {32'h8, 32'h7, 32'h6, 32'h5};
    access(1'b1, 1'b0, 32'h0000_00C0, 32'h0);
    check("missC0_busy",      n_busy, 5);
    check("missC0_wb_first",  wb_first, 1'b1);
    check("missC0_wr_cnt",    n_wr, 2);
    check("missC0_wr_addr",   wr_addr, 28'h000_0004);
    check("missC0_wr_word1",  wr_data[63:32], 32'hDEAD_BEEF);
    check("missC0_wr_word0",  wr_data[31:0], 32'h0000_0001);
    check("missC0_rd_cnt",    n_rd, 2);
    check("missC0_rd_addr",   rd_addr, 28'h000_000C);
    check("missC0_readdata",  cpu_readdata, 32'h0000_0005);

    // Clean victim: 0x40 again allocates without writeback.
    next_cycle();
    mem_wait = 2;
    mem_readdata = {32'h4, 32'h3, 32'h2, 32'h1};
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("re40_busy",     n_busy, 4);
    check("re40_wr_cnt",   n_wr, 0);
    check("re40_rd_cnt",   n_rd, 3);
    check("re40_readdata", cpu_readdata, 32'h0000_0001);

    // Reset while ALLOCATE is waiting on memory.
    next_cycle();
    mem_wait = 5;
    cpu_read = 1'b1;
    cpu_address = 32'h0000_00C0;
    @(posedge clk);
    #2;
    check("abort_alloc_active", mem_read, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_mem_read",  mem_read, 1'b0);
    check("abort_mem_write", mem_write, 1'b0);
    cpu_read = 1'b0;
    next_cycle();
    mem_wait = 0;
    mem_readdata = {32'h8, 32'h7, 32'h6, 32'h5};
    access(1'b1, 1'b0, 32'h0000_00C0, 32'h0);
    check("postrst_busy",     n_busy, 2);
    check("postrst_rd_cnt",   n_rd, 1);
    check("postrst_wr_cnt",   n_wr, 0);
    check("postrst_readdata", cpu_readdata, 32'h0000_0005);

    // Zero-wait memory, highest set.
    next_cycle();
    mem_readdata = {32'h7000_0004, 32'h7000_0003, 32'h7000_0002, 32'h7000_0001};
    access(1'b1, 1'b0, 32'h0000_0070, 32'h0);
    check("miss70_busy",     n_busy, 2);
    check("miss70_rd_cnt",   n_rd, 1);
    check("miss70_rd_addr",  rd_addr, 28'h000_0007);
    check("miss70_readdata", cpu_readdata, 32'h7000_0001);
    next_cycle();
    access(1'b1, 1'b0, 32'h0000_0074, 32'h0);
    check("rd74_readdata", cpu_readdata, 32'h7000_0002);

    // Read and write together behave as a write; then store to the last word.
    next_cycle();
    access(1'b1, 1'b1, 32'h0000_0078, 32'h1234_5678);
    check("rw78_busy", n_busy, 0);
    next_cycle();
    access(1'b0, 1'b1, 32'h0000_007C, 32'hCAFE_F00D);
    next_cycle();
    access(1'b1, 1'b0, 32'h0000_0078, 32'h0);
    check("rd78_readdata", cpu_readdata, 32'h1234_5678);

    // Tag differing only in the MSB must miss and evict the dirty set-7 line.
    next_cycle();
    mem_readdata = {32'hB, 32'hA, 32'h9, 32'h8};
    access(1'b1, 1'b0, 32'h8000_0070, 32'h0);
    check("msb_busy",     n_busy, 3);
    check("msb_wr_addr",  wr_addr, 28'h000_0007);
    check("msb_wr_data",  wr_data, {32'hCAFE_F00D, 32'h1234_5678, 32'h7000_0002, 32'h7000_0001});
    check("msb_rd_addr",  rd_addr, 28'h800_0007);
    check("msb_readdata", cpu_readdata, 32'h0000_0008);

    next_cycle();
    #1;
    check("idle_busywait", cpu_busywait, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Blocking, write-back, write-allocate, direct-mapped data-cache controller between the pipeline MEM stage and main memory.
- Owns the data, tag, valid and dirty arrays.
- Sequences miss handling (victim writeback, then block allocate) through a 3-state FSM.
- Stalls the pipeline via cpu_busywait until the access completes.

Parameters:
- NUM_SETS, 8, number of cache lines; power of two, ≥2. INDEX_BITS = clog2(NUM_SETS).
- WORDS_PER_BLOCK, 4, 32-bit words per line; power of two, ≥2. WOFF_BITS = clog2(WORDS_PER_BLOCK).
- Derived: OFFSET_BITS = WOFF_BITS+2; TAG_BITS = 32-INDEX_BITS-OFFSET_BITS; BLOCK_W = 32*WORDS_PER_BLOCK.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_read  in  1  load request; held stable while cpu_busywait=1.
- cpu_write  in  1  store request; held stable while cpu_busywait=1.
- cpu_address  in  32  byte address; bits[1:0] ignored (word access only).
- cpu_writedata  in  32  store data.
- cpu_readdata  out  32  load data; valid when cpu_read=1 and cpu_busywait=0.
- cpu_busywait  out  1  stall request to pipeline.
- mem_read  out  1  block-read request.
- mem_write  out  1  block-write request.
- mem_address  out  32-OFFSET_BITS  block address {tag,index}.
- mem_writedata  out  BLOCK_W  victim block; word 0 in bits[31:0].
- mem_readdata  in  BLOCK_W  fill block; word 0 in bits[31:0].
- mem_busywait  in  1  memory busy; transfer completes on a posedge where the request is high and mem_busywait=0.

Behaviour:
- Address split: word = addr[OFFSET_BITS-1:2]; index = addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS]; tag = addr[31:OFFSET_BITS+INDEX_BITS].
- hit = valid[index] && tag_arr[index]==tag (combinational).
- States: IDLE, WRITEBACK, ALLOCATE. Moore memory outputs decoded from the state register.
- IDLE:
  - mem_read=mem_write=0.
  - req = cpu_read|cpu_write.
  - cpu_busywait = req && !hit.
  - Read hit: cpu_readdata = selected word, same cycle, zero stall.
  - Write hit: at posedge, the word is written, dirty[index]=1, no stall.
  - Miss: next state is WRITEBACK if valid&&dirty of the victim line, else ALLOCATE.
- WRITEBACK:
  - mem_write=1; mem_address={tag_arr[index],index}; mem_writedata=data[index]; cpu_busywait=1.
  - On posedge with mem_busywait=0, go to ALLOCATE.
- ALLOCATE:
  - mem_read=1; mem_address={tag,index}; cpu_busywait=1.
  - On posedge with mem_busywait=0: data[index]=mem_readdata, tag_arr[index]=tag, valid=1, dirty=0, go to IDLE.
  - The access then hits in IDLE: a write completes there and sets dirty.
- Latency:
  - Clean miss: 2+N cycles of cpu_busywait, where N = cycles mem_busywait is high during ALLOCATE.
  - Dirty miss: adds 1+M for WRITEBACK.
  - Zero-wait memory: clean miss stalls 2 cycles (request cycle + ALLOCATE), then the hit cycle completes.
- Memory request deasserts in the cycle after completion; there are never back-to-back pulses without a state change.
- cpu_readdata = 0 unless (cpu_read && hit && state==IDLE).
- cpu_read and cpu_write both high: treated as a write.
- Request dropped mid-miss (illegal): FSM still finishes the current memory transfer, then returns to IDLE. No CPU-visible update.
- Reset, effective at posedge:
  - state=IDLE; all valid=0 and dirty=0. Data and tag arrays are not cleared.
  - Outputs after reset: mem_read=0, mem_write=0, cpu_busywait=0 (no request), cpu_readdata=0.
  - Reset mid-WRITEBACK/ALLOCATE aborts the transfer; the memory request drops the next cycle; no array update from the aborted fill.
- Index wrap: highest set (index NUM_SETS-1) behaves identically; tags compare on full TAG_BITS.

Test Plan:
- Defaults (NUM_SETS=8, WORDS_PER_BLOCK=4): reset, then cpu_read 0x0000_0040; memory busy 3 cycles and returns block words {0x4,0x3,0x2,0x1} (word 0=0x1).
  - Expect: busywait for 5 cycles, mem_read=1 with mem_address=0x0000004 for 4 cycles, no mem_write.
  - Then cpu_readdata=0x00000001 with busywait=0.
- cpu_write 0x0000_0044 data 0xDEADBEEF after the fill → busywait stays 0; next cycle cpu_read 0x44 returns 0xDEADBEEF.
- cpu_read 0x0000_00C0 (same index 4, different tag):
  - Expect WRITEBACK first: mem_write=1, mem_address=0x0000004, mem_writedata[63:32]=0xDEADBEEF.
  - Then ALLOCATE: mem_read=1, mem_address=0x000000C.
- Read 0x0000_0040 again (line clean) → mem_read only, mem_write never asserted.
- Assert reset during ALLOCATE → mem_read=0 the next cycle; a subsequent read of 0xC0 misses again (valid cleared).
- mem_busywait tied 0, read miss on 0x0000_0070 (index 7) → ALLOCATE lasts exactly 1 cycle, data returned the 3rd cycle after the request.
